// File: rtl/jk_cmd_if.sv
// Command handshake bundle for the JK command sequencer.
// The master offers op/cnt with valid, and the slave answers with ready.
interface jk_cmd_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// Drives J/K into a downstream JK flip-flop for cnt+1 cycles.
// It shadows the expected q and checks the q/qb feedback.
module jk_cmd_seq #(
  parameter int CNT_W  = 4,
  parameter int CHK_EN = 1
) (
  input  logic clk,
  input  logic rst,
  jk_cmd_if.slave cmd,
  output logic j,
  output logic k,
  input  logic q_fb,
  input  logic qb_fb,
  input  logic clr_err,
  output logic busy,
  output logic done,
  output logic err,
  output logic exp_q,
  output logic exp_vld
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_j_nxt;
  logic             w_k_nxt;
  logic             w_done_nxt;
  logic             w_mis;
  logic             w_err_nxt;
  logic             w_expq_nxt;
  logic             w_expv_nxt;

  assign cmd.cmd_ready = (r_state == IDLE);
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      exp_q   <= 1'b0;
      exp_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      j       <= w_j_nxt;
      k       <= w_k_nxt;
      done    <= w_done_nxt;
      err     <= w_err_nxt;
      exp_q   <= w_expq_nxt;
      exp_vld <= w_expv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_j_nxt     = j;
    w_k_nxt     = k;
    w_done_nxt  = 1'b0;
    w_expq_nxt  = exp_q;
    w_expv_nxt  = exp_vld;
    w_mis       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          w_j_nxt     = cmd.cmd_op[1];
          w_k_nxt     = cmd.cmd_op[0];
          w_rem_nxt   = cmd.cmd_cnt;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        // The shadow follows exactly what downstream captures this edge.
        unique case ({j, k})
          2'b01: begin
            w_expq_nxt = 1'b0;
            w_expv_nxt = 1'b1;
          end
          2'b10: begin
            w_expq_nxt = 1'b1;
            w_expv_nxt = 1'b1;
          end
          2'b11:   w_expq_nxt = ~exp_q;
          default: ;
        endcase
        if (r_rem == '0) begin
          w_j_nxt     = 1'b0;
          w_k_nxt     = 1'b0;
          w_state_nxt = CHECK;
        end else begin
          w_rem_nxt = r_rem - 1'b1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_mis = (CHK_EN != 0) &&
                ((qb_fb == q_fb) ||
                 (exp_vld && (q_fb != exp_q)));
      end
      default: w_state_nxt = IDLE;
    endcase
    w_err_nxt = w_mis | (err & ~clr_err);
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Scoreboard bench for jk_cmd_seq with a behavioural JK flip-flop
// on the feedback path and selectable feedback faults.
module tb_jk_cmd_seq;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic j, k, q_fb, qb_fb, clr_err;
  logic busy, done, err, exp_q, exp_vld;
  logic mq;
  int   fb_mode = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic eq;
    logic ev;
    logic ee;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];

  jk_cmd_if #(.CNT_W(CW)) cif ();

  jk_cmd_seq #(.CNT_W(CW), .CHK_EN(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cif.slave),
    .j       (j),
    .k       (k),
    .q_fb    (q_fb),
    .qb_fb   (qb_fb),
    .clr_err (clr_err),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .exp_q   (exp_q),
    .exp_vld (exp_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream JK flip-flop; fb_mode 1 forces q=qb=1, 2 inverts q.
  always @(posedge clk) begin
    if (!rst) mq <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   mq <= 1'b0;
        2'b10:   mq <= 1'b1;
        2'b11:   mq <= ~mq;
        default: ;
      endcase
    end
  end

  assign q_fb  = (fb_mode == 1) ? 1'b1 :
                 (fb_mode == 2) ? ~mq : mq;
  assign qb_fb = (fb_mode == 1) ? 1'b1 :
                 (fb_mode == 2) ? mq : ~mq;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst) acc_q.delete();
    else begin
      if (cif.cmd_valid && cif.cmd_ready)
        acc_q.push_back(cyc + 1);
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_exp_q", 32'(exp_q), 32'(e.eq));
          chk("done_exp_vld", 32'(exp_vld), 32'(e.ev));
          chk("done_err", 32'(err), 32'(e.ee));
          if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
          else begin
            a = acc_q.pop_front();
            chk("latency", cyc - a, e.lat);
          end
        end
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [CW-1:0] cnt,
                       logic eq, logic ev, logic ee,
                       bit push, bit keep);
    exp_t e;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_cnt   = cnt;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (cif.cmd_ready) begin
        if (push) begin
          e.eq  = eq;
          e.ev  = ev;
          e.ee  = ee;
          e.lat = int'(cnt) + 2;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) cif.cmd_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_cnt   = '0;
    clr_err       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_j", 32'(j), 0);
    chk("rst_k", 32'(k), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_exp_q", 32'(exp_q), 0);
    chk("rst_exp_vld", 32'(exp_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cif.cmd_ready), 1);
    rst = 1'b1;

    // SET cnt 0
    issue(2'b10, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("set_j", 32'(j), 1);
    chk("set_k", 32'(k), 0);
    chk("set_busy", 32'(busy), 1);
    chk("set_ready", 32'(cif.cmd_ready), 0);
    drain();
    chk("set_model_q", 32'(q_fb), 1);

    // TOGGLE cnt 2: three toggles from 1
    issue(2'b11, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("tog_j", 32'(j), 1);
    chk("tog_k", 32'(k), 1);
    drain();
    chk("tog_model_q", 32'(q_fb), 0);

    // Forced q=qb=1 feedback: sticky err until cleared
    fb_mode = 1;
    issue(2'b00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    fb_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("err_cleared", 32'(err), 0);

    // Mismatch wins over a simultaneous clear
    clr_err = 1'b1;
    fb_mode = 1;
    issue(2'b00, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("err_clr_after", 32'(err), 0);
    clr_err = 1'b0;
    fb_mode = 0;

    // Reset, then TOGGLE cnt 3 with wrong q: exp_vld=0 skips compare
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst2_exp_vld", 32'(exp_vld), 0);
    fb_mode = 2;
    issue(2'b11, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    fb_mode = 0;

    // Reset mid-DRIVE of CLEAR cnt 5 aborts with no done
    issue(2'b01, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_j", 32'(j), 0);
    chk("abort_k", 32'(k), 0);
    chk("abort_busy", 32'(busy), 0);
    rst = 1'b1;
    chk("abort_ready", 32'(cif.cmd_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_ready_late", 32'(cif.cmd_ready), 1);

    // Back-to-back with cmd_valid held high; max-count toggle
    issue(2'b10, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(2'b11, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(2'b01, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the repeat-count field.
REQ-002 SHALL have parameter CHK_EN, default 1; 1 enables the feedback check, 0 disables it.
REQ-003 SHALL have port clk, input, 1 bit; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit; a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit; the block accepts a command this cycle.
REQ-007 SHALL have port cmd_op, input, 2 bits; 00 HOLD, 01 CLEAR (k only), 10 SET (j only), 11 TOGGLE (j and k).
REQ-008 SHALL have port cmd_cnt, input, CNT_W bits; the drive lasts cmd_cnt+1 cycles.
REQ-009 SHALL have port j, output, 1 bit, registered; J drive to the downstream JK flip-flop stage.
REQ-010 SHALL have port k, output, 1 bit, registered; K drive to the downstream JK flip-flop stage.
REQ-011 SHALL have port q_fb, input, 1 bit; q fed back from the downstream stage.
REQ-012 SHALL have port qb_fb, input, 1 bit; qb fed back from the downstream stage.
REQ-013 SHALL have port clr_err, input, 1 bit; clears err synchronously.
REQ-014 SHALL have port busy, output, 1 bit; high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit; one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1 bit; sticky mismatch flag.
REQ-017 SHALL have port exp_q, output, 1 bit; shadow model of the downstream q.
REQ-018 SHALL have port exp_vld, output, 1 bit; high when exp_q is known.

Function
REQ-019 SHALL implement FSM states IDLE, DRIVE and CHECK.
REQ-020 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-021 SHALL, on the accept edge (E0), register j/k from cmd_op, load remaining counter rem = cmd_cnt, and enter DRIVE.
REQ-022 SHALL, in DRIVE: if rem == 0, set j = k = 0 and go to CHECK on the next edge; otherwise decrement rem and hold j/k.
REQ-023 SHALL hold j/k valid through edges E1..E(cnt+1); the downstream stage captures them on exactly cmd_cnt+1 edges.
REQ-024 SHALL update exp_q on each DRIVE edge: HOLD keeps it, CLEAR sets 0, SET sets 1, TOGGLE inverts.
REQ-025 SHALL set exp_vld on any CLEAR or SET drive edge; HOLD and TOGGLE leave exp_vld unchanged.
REQ-026 SHALL, in CHECK with CHK_EN = 1: set err if qb_fb == q_fb; also set err if exp_vld = 1 and q_fb != exp_q.
REQ-027 SHALL leave CHECK for IDLE after one cycle and assert done for exactly the following cycle.
REQ-028 SHALL give a latency of cmd_cnt+2 edges from accept to done rising; the earliest next accept is at E(cnt+3).
REQ-029 SHALL ignore cmd_valid while busy and not sample cmd_op or cmd_cnt.
REQ-030 SHALL give set priority to err when clr_err is high in the same cycle that CHECK detects a mismatch (err stays 1).
REQ-031 SHALL make TOGGLE with cmd_cnt = max (2^CNT_W - 1) produce exactly 2^CNT_W toggles; exp_q wraps parity correctly with no counter overflow.
REQ-032 SHALL skip the compare when CHK_EN = 0; err then stays 0.

Reset
REQ-033 SHALL, on a clk edge with rst = 0: state IDLE, j = k = 0, rem = 0, done = 0, err = 0, exp_q = 0, exp_vld = 0, busy = 0, cmd_ready = 1 from the next cycle.
REQ-034 SHALL abort the command immediately if reset occurs mid-DRIVE or mid-CHECK; no done pulse is produced.

Verification
REQ-035 SHALL verify: after reset, SET cnt = 0 -> j = 1 for 1 cycle, done at E2, exp_q = 1, exp_vld = 1, err = 0 with a correct JK model.
REQ-036 SHALL verify: after SET, TOGGLE cnt = 2 -> k = j = 1 for 3 cycles, exp_q = 0, q_fb = 0, err = 0, done at E4.
REQ-037 SHALL verify: the JK model is forced to return qb_fb = q_fb = 1 in CHECK -> err = 1 and stays 1 until clr_err pulses.
REQ-038 SHALL verify: TOGGLE cnt = 3 straight after reset -> exp_vld = 0, no q compare, err = 0, done pulses once.
REQ-039 SHALL verify: rst dropped during DRIVE of CLEAR cnt = 5 -> j = k = 0 next cycle, no done, cmd_ready = 1 afterward.
REQ-040 SHALL verify: cmd_valid held high continuously with back-to-back commands -> each is accepted only in IDLE, with exactly one done per command.
